// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller and the RISC core.
package mem_pkg;

  // Controller operating state: zeroing sweep, then normal service.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  // Default geometry, shared with the core.
  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DEPTH  = 1024;

  // Response error codes carried on rsp_err.
  localparam logic ERR_OK   = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response pipeline: RD_LAT stages of {valid, err, rdata}.
module mem_rsp_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_rdata
);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic [RD_LAT-1:0] vld_pipe;
  rsp_t [RD_LAT-1:0] dat_pipe;

  // Shift responses one stage per cycle; reset flushes everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0]       <= in_valid;
      dat_pipe[0].err   <= in_err;
      dat_pipe[0].rdata <= in_rdata;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[RD_LAT-1];
  assign out_err   = dat_pipe[RD_LAT-1].err;
  assign out_rdata = dat_pipe[RD_LAT-1].rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with valid/ready requests, fixed-latency responses,
// byte-lane writes, reserved address 0 and a zeroing sweep after reset.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int NUM_LANES = DATA_W / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_e        state, state_nxt;
  logic [IDX_W-1:0]  sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              addr_zero, addr_oob, addr_err;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word, wr_word;
  logic              pipe_err;
  logic [DATA_W-1:0] pipe_rdata;

  // State register and sweep counter; reset restarts the zeroing sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Next state and handshake outputs: ready only once the sweep is done.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      INIT: if (sweep_cnt == IDX_W'(DEPTH - 1)) state_nxt = RUN;
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Address decode at full request width, so high addresses never alias.
  assign acc       = req_valid && req_ready;
  assign addr_zero = (req_addr == '0);
  assign addr_oob  = ({1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH));
  assign addr_err  = addr_zero || addr_oob;
  assign idx       = req_addr[IDX_W-1:0];
  assign rd_word   = addr_err ? '0 : mem[idx];

  // Byte-lane merge: enabled lanes take new data, others keep the old word.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wr_word[8*l +: 8] = req_be[l] ? req_wdata[8*l +: 8] : rd_word[8*l +: 8];
  end

  // Array write: sweep zeroes one word per cycle, then legal writes commit.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[sweep_cnt] <= '0;
    else if (acc && req_write && !addr_err)
      mem[idx] <= wr_word;
  end

  // Writes and errored requests return zero data.
  assign pipe_err   = addr_err ? ERR_ADDR : ERR_OK;
  assign pipe_rdata = (req_write || addr_err) ? '0 : rd_word;

  mem_rsp_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (acc),
    .in_err    (pipe_err),
    .in_rdata  (pipe_rdata),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: RD_LAT=1 and RD_LAT=3 instances driven by shared stimulus.
module tb_data_memory_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;

  logic        rdy1, v1, err1, done1;
  logic [15:0] rdata1;
  logic        rdy3, v3, err3, done3;
  logic [15:0] rdata3;

  int errors = 0;
  int checks = 0;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(v1), .rsp_rdata(rdata1), .rsp_err(err1),
    .init_done(done1));

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(v3), .rsp_rdata(rdata3), .rsp_err(err3),
    .init_done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int stale;
    logic [15:0] vals [8];
    logic exp_v;

    // Reset state
    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_ready",   32'(rdy1),   0);
    chk("rst_valid",   32'(v1),     0);
    chk("rst_rdata",   32'(rdata1), 0);
    chk("rst_err",     32'(err1),   0);
    chk("rst_done",    32'(done1),  0);
    chk("rst_valid3",  32'(v3),     0);

    // Init sweep length
    rst_n = 1'b1;
    n = 0;
    while (!rdy1 && n < 2000) begin
      n++;
      step();
    end
    chk("init_cycles", 32'(n), 1024);
    chk("init_done",   32'(done1), 1);
    chk("init_ready3", 32'(rdy3), 1);

    // Read after init: zero
    drive(1'b0, 16'd5, 16'h0, 2'b00);
    step();
    chk("rd5_valid", 32'(v1), 1);
    chk("rd5_rdata", 32'(rdata1), 0);
    chk("rd5_err",   32'(err1), 0);

    // Write then read back-to-back
    drive(1'b1, 16'd10, 16'hBEEF, 2'b11);
    step();
    chk("wr10_valid", 32'(v1), 1);
    chk("wr10_err",   32'(err1), 0);
    chk("wr10_rdata", 32'(rdata1), 0);
    drive(1'b0, 16'd10, 16'h0, 2'b00);
    step();
    chk("rd10_valid", 32'(v1), 1);
    chk("rd10_rdata", 32'(rdata1), 32'hBEEF);
    chk("rd10_err",   32'(err1), 0);
    idle();
    step();
    chk("idle_valid", 32'(v1), 0);

    // Byte-lane merge
    drive(1'b1, 16'd7, 16'h1234, 2'b11);
    step();
    drive(1'b1, 16'd7, 16'hAB00, 2'b10);
    step();
    drive(1'b0, 16'd7, 16'h0, 2'b00);
    step();
    chk("be_rdata", 32'(rdata1), 32'hAB34);
    chk("be_err",   32'(err1), 0);

    // be=0 write changes nothing, no error
    drive(1'b1, 16'd10, 16'h5555, 2'b00);
    step();
    chk("be0_valid", 32'(v1), 1);
    chk("be0_err",   32'(err1), 0);
    drive(1'b0, 16'd10, 16'h0, 2'b00);
    step();
    chk("be0_rdata", 32'(rdata1), 32'hBEEF);

    // Reserved and out-of-range addresses
    drive(1'b1, 16'd0, 16'hFFFF, 2'b11);
    step();
    chk("wr0_err",   32'(err1), 1);
    chk("wr0_rdata", 32'(rdata1), 0);
    drive(1'b0, 16'd0, 16'h0, 2'b00);
    step();
    chk("rd0_err",   32'(err1), 1);
    chk("rd0_rdata", 32'(rdata1), 0);
    drive(1'b0, 16'd1024, 16'h0, 2'b00);
    step();
    chk("rd1024_valid", 32'(v1), 1);
    chk("rd1024_err",   32'(err1), 1);
    chk("rd1024_rdata", 32'(rdata1), 0);
    drive(1'b0, 16'hFFFF, 16'h0, 2'b00);
    step();
    chk("rdFFFF_err", 32'(err1), 1);
    drive(1'b0, 16'd0, 16'h0, 2'b00);
    step();
    chk("rd0b_rdata", 32'(rdata1), 0);
    chk("rd0b_err",   32'(err1), 1);

    // Top legal word and address 1
    drive(1'b1, 16'd1023, 16'hCAFE, 2'b11);
    step();
    chk("wr1023_err", 32'(err1), 0);
    drive(1'b0, 16'd1023, 16'h0, 2'b00);
    step();
    chk("rd1023_rdata", 32'(rdata1), 32'hCAFE);
    chk("rd1023_err",   32'(err1), 0);
    drive(1'b0, 16'd1, 16'h0, 2'b00);
    step();
    chk("rd1_err",   32'(err1), 0);
    chk("rd1_rdata", 32'(rdata1), 0);

    // RD_LAT=3 pipelined reads
    for (int i = 0; i < 8; i++) begin
      vals[i] = 16'hA000 + 16'(i) * 16'h0111;
      drive(1'b1, 16'(100 + i), vals[i], 2'b11);
      step();
    end
    idle();
    repeat (4) step();
    for (int j = 0; j <= 10; j++) begin
      if (j < 8) drive(1'b0, 16'(100 + j), 16'h0, 2'b00);
      else idle();
      step();
      exp_v = (j >= 2) && (j < 10);
      chk($sformatf("lat3_valid_%0d", j), 32'(v3), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("lat3_rdata_%0d", j), 32'(rdata3), 32'(vals[j-2]));
        chk($sformatf("lat3_err_%0d", j),   32'(err3), 0);
      end
    end

    // Reset with reads in flight
    drive(1'b0, 16'd100, 16'h0, 2'b00);
    step();
    drive(1'b0, 16'd101, 16'h0, 2'b00);
    step();
    chk("pre_rst_valid1", 32'(v1), 1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid1", 32'(v1), 0);
    chk("mid_rst_valid3", 32'(v3), 0);
    chk("mid_rst_ready",  32'(rdy1), 0);
    chk("mid_rst_done",   32'(done1), 0);
    step();
    step();
    chk("mid_rst_stale3", 32'(v3), 0);
    rst_n = 1'b1;
    n = 0;
    stale = 0;
    while (!rdy1 && n < 2000) begin
      if (v1 || v3 || done1 || done3) stale++;
      n++;
      step();
    end
    chk("reinit_cycles", 32'(n), 1024);
    chk("reinit_stale",  32'(stale), 0);
    chk("reinit_done",   32'(done1), 1);
    drive(1'b0, 16'd100, 16'h0, 2'b00);
    step();
    chk("cleared_valid1", 32'(v1), 1);
    chk("cleared_rdata1", 32'(rdata1), 0);
    idle();
    step();
    step();
    chk("cleared_valid3", 32'(v3), 1);
    chk("cleared_rdata3", 32'(rdata3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
